// File: rtl/sd_pkg.sv
// -----------------------------------------------------------------------------
// sd_pkg
// Shared definitions for the bit-serial sequence-detector path: the default
// word width and the state encoding used by the serializer. The encoding
// follows the same style as the detector's state encoding.
// Optional feature macro: SD_SER_PARITY_EN (adds a PARITY state to the serializer).
// -----------------------------------------------------------------------------
package sd_pkg;

    // Default parallel word width for the serializer feeding the detector.
    localparam int unsigned SD_WORD_W = 8;

    // Width of the state encoding.
    localparam int unsigned SD_STATE_W = 2;

    // Serializer state encoding. PARITY is only reachable when the parity
    // feature is compiled in.
    typedef enum logic [SD_STATE_W-1:0] {
        SD_IDLE   = 2'd0,
        SD_SHIFT  = 2'd1,
        SD_PARITY = 2'd2
    } sd_state_e;

endpackage : sd_pkg

// File: rtl/sd_bit_serializer.sv
// -----------------------------------------------------------------------------
// sd_bit_serializer
// Upstream feeder for the bit-serial sequence detector. Accepts parallel words
// over a valid/ready handshake and shifts them out one bit per clock. A word
// accepted in the last-bit cycle follows the previous word with no gap, so
// multi-word patterns reach the detector contiguously.
//
// Parameters:
//   WIDTH      bits per input word (2..32)
//   MSB_FIRST  1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   in_data    parallel word, sampled only on a transfer
//   in_valid   in_data is valid
//   in_ready   block can accept a word this cycle (from state/counter only)
//   dout       serial bit, drives the detector din; 0 outside SHIFT/PARITY
//   dout_valid dout carries a payload (or parity) bit
//   busy       a word is in flight
//
// Optional feature macro: SD_SER_PARITY_EN
//   When defined, each word is followed by one even-parity bit (XOR of the
//   captured word), so a word occupies WIDTH+1 cycles.
// -----------------------------------------------------------------------------
module sd_bit_serializer
    import sd_pkg::*;
#(
    parameter int unsigned WIDTH     = SD_WORD_W,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [SD_STATE_W-1:0] ST_IDLE   = SD_STATE_W'(SD_IDLE);
    localparam logic [SD_STATE_W-1:0] ST_SHIFT  = SD_STATE_W'(SD_SHIFT);
`ifdef SD_SER_PARITY_EN
    localparam logic [SD_STATE_W-1:0] ST_PARITY = SD_STATE_W'(SD_PARITY);
`endif

    logic [SD_STATE_W-1:0] state_q, state_d;
    logic [WIDTH-1:0]      shreg_q, shreg_d;
    logic [CW-1:0]         cnt_q,   cnt_d;
`ifdef SD_SER_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    logic             xfer;
    logic             last_bit;
    logic             head_bit;
    logic [WIDTH-1:0] shreg_shifted;

    // Head of the shift register and the register advanced by one bit.
    assign head_bit      = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg_q[WIDTH-1:1]};

    assign last_bit = (state_q == ST_SHIFT) && (cnt_q == '0);

    // Ready depends only on registered state, never on in_valid.
`ifdef SD_SER_PARITY_EN
    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_PARITY);
`else
    assign in_ready = (state_q == ST_IDLE) || last_bit;
`endif

    assign xfer = in_valid && in_ready;

    // State register, async active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
`ifdef SD_SER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
`ifdef SD_SER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state logic. A transfer always loads the word and (re)starts SHIFT,
    // whichever state accepted it.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
`ifdef SD_SER_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_SHIFT: begin
                shreg_d = shreg_shifted;
                if (cnt_q == '0) begin
`ifdef SD_SER_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef SD_SER_PARITY_EN
            ST_PARITY: begin
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase

        // in_ready already restricts xfer to states that may accept a word.
        if (xfer) begin
            state_d  = ST_SHIFT;
            shreg_d  = in_data;
            cnt_d    = CW'(WIDTH - 1);
`ifdef SD_SER_PARITY_EN
            parity_d = ^in_data;
`endif
        end
    end

    // Outputs decoded from registered state; dout forced low when idle.
`ifdef SD_SER_PARITY_EN
    assign dout       = (state_q == ST_SHIFT)  ? head_bit :
                        (state_q == ST_PARITY) ? parity_q : 1'b0;
    assign dout_valid = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
`else
    assign dout       = (state_q == ST_SHIFT) ? head_bit : 1'b0;
    assign dout_valid = (state_q == ST_SHIFT);
`endif

    assign busy = (state_q != ST_IDLE);

endmodule : sd_bit_serializer

// File: tb/tb_sd_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_sd_bit_serializer
// Directed bench for sd_bit_serializer: one MSB-first and one LSB-first
// instance on a shared clock and reset. Inputs change 1 time unit after the
// rising edge and outputs are sampled there too.
// Honours SD_SER_PARITY_EN: word length and parity bit follow the macro.
// -----------------------------------------------------------------------------
module tb_sd_bit_serializer;

    localparam int unsigned W = 8;
`ifdef SD_SER_PARITY_EN
    localparam bit          PAR = 1'b1;
`else
    localparam bit          PAR = 1'b0;
`endif
    localparam int unsigned WL = W + (PAR ? 1 : 0);

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_data,  in_data_l;
    logic         in_valid, in_valid_l;
    logic         in_ready, in_ready_l;
    logic         dout,     dout_l;
    logic         dout_valid, dout_valid_l;
    logic         busy,     busy_l;

    int nchecks = 0;
    int nerrors = 0;

    always #5 clk = ~clk;

    sd_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    sd_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data_l),
        .in_valid   (in_valid_l),
        .in_ready   (in_ready_l),
        .dout       (dout_l),
        .dout_valid (dout_valid_l),
        .busy       (busy_l)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected serial bit i (0-based) of a word, parity bit at index W.
    function automatic logic exp_bit(input logic [W-1:0] w, input int i, input bit msb);
        if (i >= W) return ^w;
        return msb ? w[W-1-i] : w[i];
    endfunction

    // Idle-output check for the MSB-first instance.
    task automatic chk_idle(input string tag);
        chk({tag, ".dout"},       dout,       1'b0);
        chk({tag, ".dout_valid"}, dout_valid, 1'b0);
        chk({tag, ".busy"},       busy,       1'b0);
        chk({tag, ".in_ready"},   in_ready,   1'b1);
    endtask

    // Single word through the MSB-first instance, starting from idle.
    task automatic send_word(input string tag, input logic [W-1:0] w);
        chk({tag, ".rdy0"}, in_ready, 1'b1);
        in_data  = w;
        in_valid = 1'b1;
        for (int c = 1; c <= int'(WL); c++) begin
            step();
            if (c == 1) begin
                in_valid = 1'b0;
                in_data  = 'x;
            end
            chk($sformatf("%s.dout[%0d]", tag, c), dout, exp_bit(w, c - 1, 1'b1));
            chk($sformatf("%s.vld[%0d]", tag, c), dout_valid, 1'b1);
            chk($sformatf("%s.busy[%0d]", tag, c), busy, 1'b1);
            chk($sformatf("%s.rdy[%0d]", tag, c), in_ready, logic'(c == int'(WL)));
        end
        step();
        chk_idle({tag, ".end"});
    endtask

    logic [W-1:0] w0, w1;

    initial begin
        reset      = 1'b1;
        in_data    = '0;
        in_valid   = 1'b0;
        in_data_l  = '0;
        in_valid_l = 1'b0;

        // Reset held for two cycles, then idle with X data and no valid.
        step();
        chk_idle("rst_c1");
        step();
        chk_idle("rst_c2");
        reset   = 1'b0;
        in_data = 'x;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle($sformatf("idle%0d", i));
        end
        chk("lsb_idle.rdy", in_ready_l, 1'b1);
        chk("lsb_idle.dout", dout_l, 1'b0);

        // Single word 0x66 MSB first: 0,1,1,0,0,1,1,0.
        send_word("w66", 8'h66);

        // Back-to-back 0xB6 then 0x5A with valid held; no gap between words.
        w0 = 8'hB6;
        w1 = 8'h5A;
        in_data  = w0;
        in_valid = 1'b1;
        chk("b2b.rdy[0]", in_ready, 1'b1);
        for (int c = 1; c <= int'(2 * WL); c++) begin
            step();
            if (c == 1)            in_data = w1;
            if (c == int'(WL) + 1) begin
                in_valid = 1'b0;
                in_data  = 'x;
            end
            chk($sformatf("b2b.dout[%0d]", c), dout,
                (c <= int'(WL)) ? exp_bit(w0, c - 1, 1'b1) : exp_bit(w1, c - 1 - int'(WL), 1'b1));
            chk($sformatf("b2b.vld[%0d]", c), dout_valid, 1'b1);
            chk($sformatf("b2b.rdy[%0d]", c), in_ready, logic'((c % int'(WL)) == 0));
        end
        step();
        chk_idle("b2b.end");

        // LSB-first instance, word 0x06: 0,1,1,0,0,0,0,0.
        w0 = 8'h06;
        in_data_l  = w0;
        in_valid_l = 1'b1;
        for (int c = 1; c <= int'(WL); c++) begin
            step();
            if (c == 1) in_valid_l = 1'b0;
            chk($sformatf("lsb.dout[%0d]", c), dout_l, exp_bit(w0, c - 1, 1'b0));
            chk($sformatf("lsb.vld[%0d]", c), dout_valid_l, 1'b1);
        end
        step();
        chk("lsb.end.vld", dout_valid_l, 1'b0);
        chk("lsb.end.dout", dout_l, 1'b0);
        chk("lsb.end.busy", busy_l, 1'b0);

        // Reset pulsed mid-word (bit 4 of 0xFF) between clock edges.
        in_data  = 8'hFF;
        in_valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 1) in_valid = 1'b0;
            chk($sformatf("rstmid.dout[%0d]", c), dout, 1'b1);
        end
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid.async.dout", dout,       1'b0);
        chk("rstmid.async.vld",  dout_valid, 1'b0);
        chk("rstmid.async.busy", busy,       1'b0);
        chk("rstmid.async.rdy",  in_ready,   1'b1);
        step();
        #2;
        reset = 1'b0;
        step();
        chk_idle("rstmid.after");
        send_word("w0f", 8'h0F);

        // Word 0x07: with parity, 8 payload bits then parity bit 1.
        send_word("w07", 8'h07);

        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule : tb_sd_bit_serializer
